// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Optional macro MDU_EARLY_OUT_EN: multiplies stop after the highest set bit of |b|.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [CNT_W-1:0]     mul_iters;

    logic                 is_div, neg_res, neg_rem, b_zero;
    logic [WIDTH-1:0]     a_keep;
    logic [2*WIDTH-1:0]   mcand, prod, prod_fix;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     rem, quo, dvsr, quo_fix, rem_fix;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     diff;
    logic                 q_bit;

`ifdef MDU_EARLY_OUT_EN
    function automatic logic [CNT_W-1:0] msb_iters(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] k;
        k = CNT_W'(1);
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) k = CNT_W'(i + 1);
        return k;
    endfunction
`endif

    assign start_ready = ~busy;
    assign accept      = start_valid & ~busy;

    // Unsigned ops use op[0]=1; signed ops work on magnitudes and fix signs in FIX.
    logic signed [WIDTH-1:0] a_s, b_s;
    assign a_s       = a;
    assign b_s       = b;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & (a_s < 0);
    assign b_neg     = signed_op & (b_s < 0);
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;

`ifdef MDU_EARLY_OUT_EN
    assign mul_iters = msb_iters(b_abs);
`else
    assign mul_iters = CNT_W'(WIDTH);
`endif

    // Restoring-division step: shift in next dividend bit, subtract if it fits.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dvsr};
    assign q_bit  = ~diff[WIDTH+1];

    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -quo  : quo;
    assign rem_fix  = neg_rem ? -rem  : rem;

    // Datapath working registers: no reset, loaded at the accept edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            mcand   <= {{WIDTH{1'b0}}, a_abs};
            mplier  <= b_abs;
            prod    <= '0;
            rem     <= '0;
            quo     <= a_abs;
            dvsr    <= b_abs;
            a_keep  <= a;
            is_div  <= (op[2:1] == 2'b01);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (b == '0);
        end else if (state == MUL) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (state == DIV) begin
            rem <= q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], q_bit};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'b000, 3'b001: begin
                                state <= MUL;
                                busy  <= 1'b1;
                                cnt   <= mul_iters;
                            end
                            3'b010, 3'b011: begin
                                state <= DIV;
                                busy  <= 1'b1;
                                cnt   <= CNT_W'(WIDTH);
                            end
                            3'b100: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            3'b101: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        if (b_zero) begin
                            lo          <= '1;
                            hi          <= a_keep;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (WIDTH=32); honours MDU_EARLY_OUT_EN for latencies.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_by_zero;

    int n_checks = 0;
    int n_err    = 0;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mul_lat(input int k);
        return EARLY ? k + 1 : 33;
    endfunction

    // Issue one request; returns edges from accept to done and number of busy cycles seen.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
        @(negedge clk);
        start_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat, bc, pulses;

    initial begin
        rstn = 1'b0; start_valid = 1'b0; op = 3'b110; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", {32'b0, hi}, 64'h0);
        chk("reset_lo", {32'b0, lo}, 64'h0);
        chk("reset_ctl", {61'b0, busy, done, div_by_zero}, 64'h0);
        chk("reset_ready", {63'b0, start_ready}, 64'h1);
        @(negedge clk) rstn = 1'b1;

        // MULT -3 * 5
        issue(3'b000, 32'hFFFF_FFFD, 32'd5, lat, bc);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mult_lat", lat, mul_lat(3));
        chk("mult_busy", bc, mul_lat(3));

        issue(3'b011, 32'd100, 32'd7, lat, bc);
        chk("divu", {hi, lo}, {32'd2, 32'd14});
        chk("divu_lat", lat, 33);
        chk("divu_busy", bc, 33);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bc);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("div_ovf_flag", {63'b0, div_by_zero}, 64'h0);

        issue(3'b010, 32'd1234, 32'd0, lat, bc);
        chk("div0", {hi, lo}, {32'd1234, 32'hFFFF_FFFF});
        chk("div0_flag", {63'b0, div_by_zero}, 64'h1);
        chk("div0_lat", lat, 33);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("multu_max_lat", lat, 33);

        issue(3'b001, 32'd3, 32'd0, lat, bc);
        chk("multu_b0", {hi, lo}, 64'h0);
        chk("multu_b0_lat", lat, mul_lat(1));

        // MTHI then MTLO back-to-back
        issue(3'b100, 32'hA5A5_A5A5, 32'd0, lat, bc);
        chk("mthi", {32'b0, hi}, {32'b0, 32'hA5A5_A5A5});
        chk("mthi_lat_busy", {lat[31:0], bc[31:0]}, 64'h0);
        issue(3'b101, 32'h5A5A_5A5A, 32'd0, lat, bc);
        chk("mtlo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
        chk("mtlo_lat_busy", {lat[31:0], bc[31:0]}, 64'h0);

        // No-op: accepted, no state change, no done
        @(negedge clk);
        start_valid = 1'b1; op = 3'b110; a = 32'h1111_1111;
        @(posedge clk); #1;
        start_valid = 1'b0;
        pulses = 0;
        repeat (5) begin
            if (done || busy) pulses++;
            @(posedge clk); #1;
        end
        chk("noop_quiet", pulses, 0);
        chk("noop_regs", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);

        // MTHI held while MULTU 3*1 is busy
        @(negedge clk);
        start_valid = 1'b1; op = 3'b001; a = 32'd3; b = 32'd1;
        @(posedge clk); #1;
        op = 3'b100; a = 32'hDEAD_BEEF;
        chk("busy_not_ready", {63'b0, start_ready}, 64'h0);
        lat = 0; pulses = 0;
        while (!done && lat < 100) begin
            if (hi !== 32'hA5A5_A5A5) pulses++;
            @(posedge clk); #1;
            lat++;
        end
        chk("held_hi_stable", pulses, 0);
        chk("multu_small", {hi, lo}, 64'h3);
        chk("multu_small_lat", lat, mul_lat(1));
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("held_mthi", {31'b0, done, hi}, {31'b0, 1'b1, 32'hDEAD_BEEF});

        // Reset in the middle of a DIV
        @(negedge clk);
        start_valid = 1'b1; op = 3'b011; a = 32'd500; b = 32'd3;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        #1;
        chk("midrst_regs", {hi, lo}, 64'h0);
        chk("midrst_ctl", {61'b0, busy, done, div_by_zero}, 64'h0);
        @(negedge clk) rstn = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        issue(3'b011, 32'd100, 32'd7, lat, bc);
        chk("after_rst_divu", {hi, lo}, {32'd2, 32'd14});
        chk("after_rst_lat", lat, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
